// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - sweeps decoder select code through all 16 values with programmable dwell
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dir_down,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               active,
    output logic               step,
    output logic               wrap,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t             state;
    logic [3:0]         sel;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_lat;
    logic               dir_lat;
    logic               mode_lat;

    logic [DWELL_W-1:0] dwell_eff;
    logic [3:0]         term_code;
    logic [3:0]         start_code;
    logic [3:0]         next_code;

    // A zero dwell means one cycle per code; the sweep endpoints follow the latched direction.
    always_comb begin
        dwell_eff  = (dwell == '0) ? DWELL_ONE : dwell;
        term_code  = dir_lat ? 4'h0 : 4'hF;
        start_code = dir_lat ? 4'hF : 4'h0;
        next_code  = dir_lat ? (sel - 4'd1) : (sel + 4'd1);
    end

    // Sequencer state, select code, dwell counter and strobes, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 4'h0;
            cnt       <= '0;
            dwell_lat <= '0;
            dir_lat   <= 1'b0;
            mode_lat  <= 1'b0;
            active    <= 1'b0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sel    <= 4'h0;
                    active <= 1'b0;
                    // stop wins over a simultaneous start
                    if (start && !stop) begin
                        dir_lat   <= dir_down;
                        mode_lat  <= mode_cont;
                        dwell_lat <= dwell_eff;
                        state     <= SCAN;
                        sel       <= dir_down ? 4'hF : 4'h0;
                        cnt       <= dwell_eff - DWELL_ONE;
                        active    <= 1'b1;
                        step      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state  <= IDLE;
                        sel    <= 4'h0;
                        active <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_ONE;
                    end else if (sel != term_code) begin
                        sel  <= next_code;
                        cnt  <= dwell_lat - DWELL_ONE;
                        step <= 1'b1;
                    end else if (mode_lat) begin
                        sel  <= start_code;
                        cnt  <= dwell_lat - DWELL_ONE;
                        step <= 1'b1;
                        wrap <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        sel    <= 4'h0;
                        active <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sel    <= 4'h0;
                    active <= 1'b0;
                end
            endcase
        end
    end

    assign {a, b, c, d} = sel;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - self-checking bench for scan_sequencer
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir_down;
    logic       mode_cont;
    logic [7:0] dwell;
    logic       a, b, c, d;
    logic       active, step, wrap, done;

    int checks = 0;
    int errors = 0;

    // model state
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_dir    = 1'b0;
    bit m_mode   = 1'b0;
    int m_d      = 1;
    int m_t      = 0;

    // observation counters
    bit check_en   = 1'b0;
    int step_count = 0;
    int act_count  = 0;
    int wrap_count = 0;
    int done_count = 0;
    int bad_onehot = 0;
    int step_sel [0:63];

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dir_down  (dir_down),
        .mode_cont (mode_cont),
        .dwell     (dwell),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .active    (active),
        .step      (step),
        .wrap      (wrap),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts cycles since the sweep began; code index is t/D modulo 16.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1;
                m_dir    = dir_down;
                m_mode   = mode_cont;
                m_d      = (dwell == 0) ? 1 : int'(dwell);
                m_t      = 0;
            end
        end else if (stop) begin
            m_active = 1'b0;
        end else begin
            m_t++;
            if (!m_mode && m_t == 16 * m_d) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    end

    function automatic int exp_sel();
        int idx;
        if (!m_active) return 0;
        idx = (m_t / m_d) % 16;
        return m_dir ? 15 - idx : idx;
    endfunction

    // Compare DUT against the model one time unit after every rising edge.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            check("sel",    int'({a, b, c, d}), exp_sel());
            check("active", int'(active), int'(m_active));
            check("step",   int'(step), (m_active && (m_t % m_d == 0)) ? 1 : 0);
            check("wrap",   int'(wrap), (m_active && m_mode && m_t > 0 && (m_t % (16 * m_d) == 0)) ? 1 : 0);
            check("done",   int'(done), int'(m_done));
        end
        if (step) begin
            if (step_count < 64) step_sel[step_count] = int'({a, b, c, d});
            step_count++;
        end
        if (active) begin
            act_count++;
            if (!$onehot(16'h1 << {a, b, c, d})) bad_onehot++;
        end
        if (wrap) wrap_count++;
        if (done) done_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        step_count = 0;
        act_count  = 0;
        wrap_count = 0;
        done_count = 0;
        bad_onehot = 0;
    endtask

    task automatic start_sweep(input int dw, input bit dn, input bit mc);
        dwell     = 8'(dw);
        dir_down  = dn;
        mode_cont = mc;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    // Returns cycles elapsed until done is seen (bounded).
    task automatic wait_done(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            tick(1);
            n++;
            if (done) break;
        end
        if (!done) check("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_sel(input int code, input int maxc);
        int n;
        n = 0;
        while (n < maxc && int'({a, b, c, d}) != code) begin
            tick(1);
            n++;
        end
        check("wait_sel_reached", int'({a, b, c, d}), code);
    endtask

    initial begin
        int n;
        int wrap_at;
        int bad;
        int snap;
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir_down = 1'b0; mode_cont = 1'b0; dwell = 8'd0;
        tick(2);
        check("reset_sel",    int'({a, b, c, d}), 0);
        check("reset_active", int'(active), 0);
        check("reset_strobe", int'({step, wrap, done}), 0);
        rst = 1'b0;
        check_en = 1'b1;
        tick(1);

        // start and stop together in IDLE: stop wins
        dwell = 8'd2; start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        check("startstop_active", int'(active), 0);
        check("startstop_out", int'({a, b, c, d, step}), 0);
        tick(3);
        check("startstop_still_idle", int'(active), 0);

        // single up sweep, dwell 3
        clear_counts();
        start_sweep(3, 1'b0, 1'b0);
        wait_done(100, n);
        check("up_done_cycle", n + 1, 49);
        check("up_active_cycles", act_count, 48);
        check("up_steps", step_count, 16);
        check("up_done_sel", int'({a, b, c, d}), 0);
        check("up_done_active", int'(active), 0);
        check("up_onehot", bad_onehot, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (step_sel[i] != i) bad++;
        check("up_order", bad, 0);
        tick(1);
        check("up_done_pulse_once", done_count, 1);

        // down sweep, dwell 0 treated as 1
        clear_counts();
        start_sweep(0, 1'b1, 1'b0);
        wait_done(40, n);
        check("down_done_cycle", n + 1, 17);
        check("down_active_cycles", act_count, 16);
        check("down_steps", step_count, 16);
        check("down_first", step_sel[0], 15);
        check("down_last", step_sel[15], 0);
        tick(2);

        // continuous up, dwell 2, then stop at code 3
        clear_counts();
        wrap_at = 0;
        start_sweep(2, 1'b0, 1'b1);
        n = 1;
        while (n < 40) begin
            tick(1);
            n++;
            if (wrap && wrap_at == 0) wrap_at = n;
        end
        check("cont_wrap_cycle", wrap_at, 33);
        check("cont_wrap_count", wrap_count, 1);
        check("cont_no_done", done_count, 0);
        wait_sel(3, 40);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_active", int'(active), 0);
        check("stop_sel", int'({a, b, c, d}), 0);
        check("stop_no_done", int'(done), 0);
        tick(2);

        // inputs changed mid-sweep have no effect
        clear_counts();
        start_sweep(2, 1'b0, 1'b0);
        tick(4);
        dwell = 8'd5; dir_down = 1'b1; mode_cont = 1'b1;
        wait_done(100, n);
        check("latched_done_cycle", n + 5, 33);
        bad = 0;
        for (int i = 0; i < 16; i++) if (step_sel[i] != i) bad++;
        check("latched_order", bad, 0);

        // start accepted on the done cycle
        dwell = 8'd1; dir_down = 1'b0; mode_cont = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_active", int'(active), 1);
        check("restart_sel", int'({a, b, c, d}), 0);
        check("restart_step", int'(step), 1);
        tick(3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);

        // reset mid-sweep
        clear_counts();
        start_sweep(3, 1'b0, 1'b0);
        wait_sel(5, 40);
        rst = 1'b1;
        tick(1);
        check("midrst_sel", int'({a, b, c, d}), 0);
        check("midrst_active", int'(active), 0);
        check("midrst_done", int'(done), 0);
        tick(1);
        rst = 1'b0;
        snap = step_count;
        tick(10);
        check("midrst_no_steps", step_count, snap);
        check("midrst_no_done", done_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
